// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory behind the load/store unit.
// Synchronous byte/half/word stores, combinational zero-extended loads, preset on reset.
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [IDX_W-1:0] index_s;
    logic [3:0]       byte_en_s;
    logic [31:0]      wdata_s;
    logic [31:0]      word_s;
    logic             unused_s;

    // Upper address bits do not decode, so accesses wrap modulo the array size.
    assign index_s  = address[IDX_W+1:2];
    assign word_s   = mem_r[index_s];
    assign unused_s = ^{address[31:IDX_W+2], 1'b0};

    // Store lane enables; data is replicated so each lane sees its byte in place.
    always_comb begin
        byte_en_s = 4'b0000;
        wdata_s   = 32'h0000_0000;
        case (mem_size)
            2'b00: begin
                byte_en_s = 4'b0001 << address[1:0];
                wdata_s   = {4{write_data[7:0]}};
            end
            2'b01: begin
                if (address[1]) begin
                    byte_en_s = 4'b1100;
                end else begin
                    byte_en_s = 4'b0011;
                end
                wdata_s = {2{write_data[15:0]}};
            end
            2'b10: begin
                byte_en_s = 4'b1111;
                wdata_s   = write_data;
            end
            default: begin
                byte_en_s = 4'b0000;
                wdata_s   = 32'h0000_0000;
            end
        endcase
    end

    // Storage array: preset on reset, byte-lane writes on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h1000_0000 + 32'(i);
            end
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[index_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Load path: zero-extended lane select, forced to zero when not reading.
    always_comb begin
        read_data = 32'h0000_0000;
        if (mem_read) begin
            case (mem_size)
                2'b00: read_data = {24'h00_0000, word_s[8*address[1:0] +: 8]};
                2'b01: begin
                    if (address[1]) begin
                        read_data = {16'h0000, word_s[31:16]};
                    end else begin
                        read_data = {16'h0000, word_s[15:0]};
                    end
                end
                2'b10:   read_data = word_s;
                default: read_data = 32'h0000_0000;
            endcase
        end else begin
            read_data = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected load values are queued as each
// load is driven and compared when the combinational result is sampled.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks_r;
    int errors_r;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    data_memory #(.DEPTH_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_r++;
        if (actual !== expected) begin
            errors_r++;
            $display("FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT drives now.
    task automatic sample_and_check();
        logic [31:0] exp_v;
        string       tag_v;
        if (exp_q.size() == 0) begin
            checks_r++;
            errors_r++;
            $display("FAIL scoreboard_empty: got %0d expected >0", exp_q.size());
        end else begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            check_eq(tag_v, read_data, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp_v);
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
    endtask

    // Load between edges, away from the rising edge.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                           input logic rd, input logic [31:0] exp_v);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = rd;
        mem_size  = sz;
        address   = addr;
        push_exp(tag, exp_v);
        #1;
        sample_and_check();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
        @(negedge clk);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        mem_size   = sz;
        address    = addr;
        write_data = data;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = SZ_W;
        address    = 32'h0000_0000;
        write_data = 32'h0000_0000;

        // Preset contents visible while reset is still held.
        do_load("rst_read_w1", 32'h0000_0004, SZ_W, 1'b1, 32'h1000_0001);
        do_load("rst_noread", 32'h0000_0004, SZ_W, 1'b0, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        do_load("preset_w0", 32'h0000_0000, SZ_W, 1'b1, 32'h1000_0000);
        do_load("preset_w1", 32'h0000_0004, SZ_W, 1'b1, 32'h1000_0001);
        do_load("preset_w2", 32'h0000_0008, SZ_W, 1'b1, 32'h1000_0002);
        do_load("read_off", 32'h0000_0000, SZ_W, 1'b0, 32'h0000_0000);

        do_store(32'h0000_0010, SZ_B, 32'h1234_56AB);
        do_load("byte_10", 32'h0000_0010, SZ_B, 1'b1, 32'h0000_00AB);
        do_load("word_10_b", 32'h0000_0010, SZ_W, 1'b1, 32'h1000_00AB);
        do_load("byte_11", 32'h0000_0011, SZ_B, 1'b1, 32'h0000_0000);
        do_load("byte_13", 32'h0000_0013, SZ_B, 1'b1, 32'h0000_0010);

        do_store(32'h0000_0012, SZ_H, 32'h9999_CDEF);
        do_load("half_12", 32'h0000_0012, SZ_H, 1'b1, 32'h0000_CDEF);
        do_load("word_10_h", 32'h0000_0010, SZ_W, 1'b1, 32'hCDEF_00AB);
        do_store(32'h0000_0013, SZ_H, 32'h0000_5555);
        do_load("half_13", 32'h0000_0013, SZ_H, 1'b1, 32'h0000_5555);
        do_load("word_10_h2", 32'h0000_0010, SZ_W, 1'b1, 32'h5555_00AB);
        do_load("half_10", 32'h0000_0010, SZ_H, 1'b1, 32'h0000_00AB);

        do_store(32'h0000_0014, SZ_W, 32'hDEAD_BEEF);
        do_load("word_14", 32'h0000_0014, SZ_W, 1'b1, 32'hDEAD_BEEF);
        do_load("byte_17", 32'h0000_0017, SZ_B, 1'b1, 32'h0000_00DE);
        do_load("byte_15", 32'h0000_0015, SZ_B, 1'b1, 32'h0000_00BE);
        do_load("half_14", 32'h0000_0014, SZ_H, 1'b1, 32'h0000_BEEF);
        do_load("half_16", 32'h0000_0016, SZ_H, 1'b1, 32'h0000_DEAD);
        do_load("word_17", 32'h0000_0017, SZ_W, 1'b1, 32'hDEAD_BEEF);

        // Word store with misaligned address lands on the enclosing word.
        do_store(32'h0000_001B, SZ_W, 32'h0102_0304);
        do_load("word_18", 32'h0000_0018, SZ_W, 1'b1, 32'h0102_0304);

        do_store(32'h0000_0008, SZ_X, 32'h1234_5678);
        do_load("rsvd_store", 32'h0000_0008, SZ_W, 1'b1, 32'h1000_0002);
        do_load("rsvd_load", 32'h0000_0008, SZ_X, 1'b1, 32'h0000_0000);

        do_store(32'h0000_0400, SZ_W, 32'hCAFE_F00D);
        do_load("wrap_w0", 32'h0000_0000, SZ_W, 1'b1, 32'hCAFE_F00D);
        do_load("wrap_hi", 32'hFFFF_FC00, SZ_W, 1'b1, 32'hCAFE_F00D);
        do_load("w1_intact", 32'h0000_0004, SZ_W, 1'b1, 32'h1000_0001);

        // Simultaneous read/write: old data before the edge, new after.
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        mem_size   = SZ_W;
        address    = 32'h0000_0020;
        write_data = 32'h1122_3344;
        push_exp("rw_before", 32'h1000_0008);
        #1;
        sample_and_check();
        push_exp("rw_after", 32'h1122_3344);
        @(posedge clk);
        #1;
        sample_and_check();
        mem_write = 1'b0;

        do_store(32'h0000_0023, SZ_B, 32'h0000_0077);
        do_load("byte_lane3", 32'h0000_0020, SZ_W, 1'b1, 32'h7722_3344);

        // Reset asserted mid-cycle with a store pending: preset returns at once.
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        mem_size   = SZ_W;
        address    = 32'h0000_0014;
        write_data = 32'hFFFF_FFFF;
        #1;
        rst = 1'b1;
        push_exp("rst_async_14", 32'h1000_0005);
        #1;
        sample_and_check();
        @(posedge clk);
        #1;
        push_exp("rst_store_ign", 32'h1000_0005);
        sample_and_check();
        mem_write = 1'b0;
        do_load("rst_w4", 32'h0000_0010, SZ_W, 1'b1, 32'h1000_0004);
        @(negedge clk);
        rst = 1'b0;
        do_load("post_rst_14", 32'h0000_0014, SZ_W, 1'b1, 32'h1000_0005);
        do_load("post_rst_w0", 32'h0000_0000, SZ_W, 1'b1, 32'h1000_0000);
        do_load("post_rst_w8", 32'h0000_0020, SZ_W, 1'b1, 32'h1000_0008);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
